// File: rtl/light_sensor_acq_if.sv
// ADC handshake bundle between the acquisition stage (master) and the sensor mux/converter (slave).
interface light_sensor_acq_if;
    logic [1:0] adc_ch;
    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;

    modport master (output adc_ch, output adc_start, input adc_done, input adc_data);
    modport slave  (input adc_ch, input adc_start, output adc_done, output adc_data);
endinterface

// File: rtl/light_sensor_acq.sv
// Light-sensor acquisition: cycles the shared ADC over N/E/S/W, averages 2^AVG_LOG2 samples per
// channel and publishes a coherent frame. Optional macro LS_ADC_TIMEOUT_EN adds a WAIT timeout.
module light_sensor_acq #(
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    light_sensor_acq_if.master adc,
    output logic [7:0]         lsn,
    output logic [7:0]         lse,
    output logic [7:0]         lss,
    output logic [7:0]         lsw,
    output logic               frame_valid,
    output logic               adc_err
);
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE + 2);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_START, ST_WAIT, ST_PUBLISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] samp_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       shadow [4];
    logic [7:0]       sample;
    logic [ACC_W-1:0] sum;
    logic [7:0]       avg;
    logic             accept;

`ifdef LS_ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            err_flag;
    logic            timed_out;
    logic            publish_now;

    // An abandoned conversion falls back to the channel's previous average as its sample.
    assign timed_out   = (state == ST_WAIT) && !adc.adc_done && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign accept      = (state == ST_WAIT) && (adc.adc_done || timed_out);
    assign publish_now = accept && (samp_cnt == LAST_SAMPLE) && (adc.adc_ch == 2'd3);
    assign sample      = adc.adc_done ? adc.adc_data : shadow[adc.adc_ch];
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign accept         = (state == ST_WAIT) && adc.adc_done;
    assign sample         = adc.adc_data;
    assign adc_err        = 1'b0;
`endif

    assign sum = acc + ACC_W'(sample);
    assign avg = 8'(sum >> AVG_LOG2);

    // Sequencer: outputs are registered, so adc_start and frame_valid are set on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            adc.adc_ch      <= 2'd0;
            adc.adc_start   <= 1'b0;
            frame_valid     <= 1'b0;
            lsn             <= 8'd0;
            lse             <= 8'd0;
            lss             <= 8'd0;
            lsw             <= 8'd0;
            acc             <= '0;
            samp_cnt        <= '0;
            settle_cnt      <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= 8'd0;
        end else begin
            adc.adc_start <= 1'b0;
            frame_valid   <= 1'b0;
            case (state)
                ST_IDLE, ST_PUBLISH: begin
                    adc.adc_ch <= 2'd0;
                    settle_cnt <= '0;
                    if (SETTLE == 0) begin
                        state         <= ST_START;
                        adc.adc_start <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        state         <= ST_START;
                        adc.adc_start <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (accept) begin
                        if (samp_cnt == LAST_SAMPLE) begin
                            shadow[adc.adc_ch] <= avg;
                            acc                <= '0;
                            samp_cnt           <= '0;
                            if (adc.adc_ch == 2'd3) begin
                                // The last average bypasses its shadow so all four land together.
                                state       <= ST_PUBLISH;
                                frame_valid <= 1'b1;
                                lsn         <= shadow[0];
                                lse         <= shadow[1];
                                lss         <= shadow[2];
                                lsw         <= avg;
                            end else begin
                                adc.adc_ch <= adc.adc_ch + 2'd1;
                                settle_cnt <= '0;
                                if (SETTLE == 0) begin
                                    state         <= ST_START;
                                    adc.adc_start <= 1'b1;
                                end else begin
                                    state <= ST_SETTLE;
                                end
                            end
                        end else begin
                            acc           <= sum;
                            samp_cnt      <= samp_cnt + CNT_W'(1);
                            state         <= ST_START;
                            adc.adc_start <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LS_ADC_TIMEOUT_EN
    // The error flag collects timeouts over a frame and is handed to adc_err at publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
            adc_err  <= 1'b0;
        end else begin
            if (state != ST_WAIT) begin
                wait_cnt <= '0;
            end else if (!accept) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (publish_now) begin
                adc_err  <= err_flag | timed_out;
                err_flag <= 1'b0;
            end else if (timed_out) begin
                err_flag <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_light_sensor_acq.sv
// Directed bench for light_sensor_acq: behavioural ADC models drive two configurations and the
// published frames are checked against hand-computed averages and frame periods.
module tb_light_sensor_acq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    light_sensor_acq_if bus0();
    light_sensor_acq_if bus1();

    logic [7:0] lsn, lse, lss, lsw;
    logic       frame_valid, adc_err;
    logic [7:0] lsn1, lse1, lss1, lsw1;
    logic       frame_valid1, adc_err1;

    light_sensor_acq #(.AVG_LOG2(2), .SETTLE(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .adc(bus0),
        .lsn(lsn), .lse(lse), .lss(lss), .lsw(lsw),
        .frame_valid(frame_valid), .adc_err(adc_err)
    );

    light_sensor_acq #(.AVG_LOG2(0), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .adc(bus1),
        .lsn(lsn1), .lse(lse1), .lss(lss1), .lsw(lsw1),
        .frame_valid(frame_valid1), .adc_err(adc_err1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ADC model for dut: answers each start after delay0 WAIT cycles, optionally injecting noise.
    logic [7:0] chval [4];
    logic [7:0] nseq [4];
    int         delay0   = 1;
    bit         rand_en  = 1'b0;
    bit         spur_en  = 1'b0;
    bit         seq_en   = 1'b0;
    bit         withhold = 1'b0;
    int         nidx     = 0;
    int         lat_idx  = 0;
    int         cd       = 0;
    logic [1:0] lat_ch   = 2'd0;

    initial begin
        bus0.adc_done = 1'b0;
        bus0.adc_data = 8'd0;
        forever begin
            @(negedge clk);
            bus0.adc_done = 1'b0;
            if (rand_en) begin
                bus0.adc_done = 1'($urandom);
                bus0.adc_data = 8'($urandom);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus0.adc_done = 1'b1;
                    bus0.adc_data = (lat_ch == 2'd0 && seq_en) ? nseq[lat_idx] : chval[lat_ch];
                end
            end else if (bus0.adc_start) begin
                lat_ch = bus0.adc_ch;
                if (lat_ch == 2'd0) begin
                    lat_idx = nidx;
                    nidx    = (nidx + 1) % 4;
                end
                if (withhold && lat_ch == 2'd1) withhold = 1'b0;
                else cd = delay0;
            end else if (spur_en) begin
                bus0.adc_done = 1'b1;
                bus0.adc_data = 8'hAA;
            end
        end
    end

    // ADC model for dut1: fixed one-cycle latency.
    logic [7:0] chval1 [4];
    bit         pend1 = 1'b0;
    logic [1:0] pch1  = 2'd0;

    initial begin
        bus1.adc_done = 1'b0;
        bus1.adc_data = 8'd0;
        forever begin
            @(negedge clk);
            bus1.adc_done = pend1;
            bus1.adc_data = pend1 ? chval1[pch1] : 8'h00;
            pend1 = bus1.adc_start;
            pch1  = bus1.adc_ch;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    int starts [4];
    int ch_order;
    int prev_ch;

    task automatic waitFrame(input int budget, output int cycles);
        for (int i = 0; i < 4; i++) starts[i] = 0;
        ch_order = 0;
        prev_ch  = -1;
        cycles   = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (bus0.adc_start === 1'b1) begin
                starts[bus0.adc_ch]++;
                if (int'(bus0.adc_ch) != prev_ch) begin
                    ch_order = (ch_order << 4) | int'(bus0.adc_ch);
                    prev_ch  = int'(bus0.adc_ch);
                end
            end
        end while (frame_valid !== 1'b1 && cycles < budget);
        checkOutput("frame_seen", 32'(frame_valid), 1);
    endtask

    task automatic checkFrame(input string pfx, input int en, input int ee, input int es,
                              input int ew, input int err);
        checkOutput({pfx, "_lsn"}, 32'(lsn), en);
        checkOutput({pfx, "_lse"}, 32'(lse), ee);
        checkOutput({pfx, "_lss"}, 32'(lss), es);
        checkOutput({pfx, "_lsw"}, 32'(lsw), ew);
        checkOutput({pfx, "_err"}, 32'(adc_err), err);
    endtask

    task automatic checkZero(input string pfx);
        checkOutput({pfx, "_lsn"}, 32'(lsn), 0);
        checkOutput({pfx, "_lse"}, 32'(lse), 0);
        checkOutput({pfx, "_lss"}, 32'(lss), 0);
        checkOutput({pfx, "_lsw"}, 32'(lsw), 0);
        checkOutput({pfx, "_fv"}, 32'(frame_valid), 0);
        checkOutput({pfx, "_err"}, 32'(adc_err), 0);
        checkOutput({pfx, "_ch"}, 32'(bus0.adc_ch), 0);
    endtask

    task automatic checkStarts(input string pfx);
        checkOutput({pfx, "_order"}, 32'(ch_order), 32'h123);
        for (int i = 0; i < 4; i++) checkOutput({pfx, "_starts"}, 32'(starts[i]), 4);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        bit  start_seen;
        bit  found;

        chval  = '{8'd200, 8'd50, 8'd100, 8'd255};
        nseq   = '{8'd10, 8'd11, 8'd12, 8'd13};
        chval1 = '{8'd13, 8'd7, 8'd0, 8'd255};

        // Reset held with random ADC activity: everything quiet and zero.
        #2 rst_n = 1'b0;
        rand_en    = 1'b1;
        start_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.adc_start !== 1'b0 || bus1.adc_start !== 1'b0) start_seen = 1'b1;
        end
        checkOutput("rst_no_start", 32'(start_seen), 0);
        checkZero("rst");
        rand_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First frame after release, then steady-state period.
        waitFrame(200, cyc);
        checkOutput("first_latency", 32'(cyc), 49);
        checkStarts("f1");
        checkFrame("f1", 200, 50, 100, 255, 0);
        waitFrame(200, cyc);
        checkOutput("period_d1", 32'(cyc), 49);
        checkFrame("f2", 200, 50, 100, 255, 0);

        // Second instance: single-sample averages, no settle.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (frame_valid1 === 1'b1) found = 1'b1;
        end
        checkOutput("d1_frame_seen", 32'(found), 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (frame_valid1 !== 1'b1 && cyc < 40);
        checkOutput("d1_period", 32'(cyc), 9);
        checkOutput("d1_lsn", 32'(lsn1), 13);
        checkOutput("d1_lse", 32'(lse1), 7);
        checkOutput("d1_lss", 32'(lss1), 0);
        checkOutput("d1_lsw", 32'(lsw1), 255);

        // Varying N samples: (10+11+12+13)>>2 truncates to 11.
        waitFrame(200, cyc);
        seq_en = 1'b1;
        nidx   = 0;
        waitFrame(200, cyc);
        checkFrame("avg", 11, 50, 100, 255, 0);

        // Slow ADC with spurious done pulses outside WAIT.
        seq_en  = 1'b0;
        delay0  = 7;
        spur_en = 1'b1;
        waitFrame(400, cyc);
        checkOutput("period_d7", 32'(cyc), 145);
        checkFrame("slow", 200, 50, 100, 255, 0);
        delay0  = 1;
        spur_en = 1'b0;
        waitFrame(400, cyc);

        // Reset during a channel-2 WAIT discards the partial frame.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus0.adc_start === 1'b1 && bus0.adc_ch == 2'd2) found = 1'b1;
        end
        checkOutput("ch2_start_seen", 32'(found), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkZero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitFrame(200, cyc);
        checkOutput("restart_latency", 32'(cyc), 49);
        checkStarts("rs");
        checkFrame("rs", 200, 50, 100, 255, 0);

`ifdef LS_ADC_TIMEOUT_EN
        // One withheld conversion on E: sample falls back to previous average 50 -> (50+3*80)>>2.
        chval[1] = 8'd80;
        withhold = 1'b1;
        waitFrame(400, cyc);
        checkOutput("period_timeout", 32'(cyc), 64);
        checkFrame("to", 200, 72, 100, 255, 1);
        waitFrame(200, cyc);
        checkOutput("period_clean", 32'(cyc), 49);
        checkFrame("clean", 200, 80, 100, 255, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
